// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: shared-memory port bundle between VGA, CPU, DMA clients, the SRAM and the slot arbiter.
// The arbiter connects through the slave modport; the client/memory environment uses master.
interface mem_arbiter_if #(
    parameter int DATAWIDTH = 16
);
    logic [2:0]           acnt;
    logic [DATAWIDTH-1:0] vga_addr;
    logic [DATAWIDTH-1:0] vga_rdata;
    logic                 vga_rvalid;
    logic                 cpu_req;
    logic                 cpu_we;
    logic [DATAWIDTH-1:0] cpu_addr;
    logic [DATAWIDTH-1:0] cpu_wdata;
    logic                 cpu_gnt;
    logic                 cpu_rvalid;
    logic [DATAWIDTH-1:0] cpu_rdata;
    logic                 dma_req;
    logic                 dma_we;
    logic [DATAWIDTH-1:0] dma_addr;
    logic [DATAWIDTH-1:0] dma_wdata;
    logic                 dma_gnt;
    logic                 dma_rvalid;
    logic [DATAWIDTH-1:0] dma_rdata;
    logic [DATAWIDTH-1:0] mem_addr;
    logic                 mem_we;
    logic [DATAWIDTH-1:0] mem_wdata;
    logic [DATAWIDTH-1:0] mem_rdata;

    modport slave (
        output acnt,
        input  vga_addr,
        output vga_rdata, vga_rvalid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        input  acnt,
        output vga_addr,
        input  vga_rdata, vga_rvalid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: 8-slot time-division arbiter for the shared SRAM port (slots 0/1 VGA, 2-7 CPU/DMA round-robin).
// Read data returns to the tagged owner RD_LAT+2 cycles after the arbitration cycle.
module mem_arbiter #(
    parameter int DATAWIDTH = 16,
    parameter int RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CPU, TAG_DMA} tag_e;

    logic [2:0]           acnt_q;
    logic [DATAWIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                 mem_we_q, mem_we_d;
    logic                 cpu_gnt_q, dma_gnt_q;
    logic                 last_cpu_q, last_cpu_d;
    logic [DATAWIDTH-1:0] vga_rdata_q, cpu_rdata_q, dma_rdata_q;
    logic                 vga_rvalid_q, cpu_rvalid_q, dma_rvalid_q;
    logic                 vga_slot, cpu_el, dma_el, cpu_win, dma_win;
    tag_e                 tag_d, ret;
    tag_e                 tag_q [RD_LAT+1];

    always_comb begin
        vga_slot    = acnt_q[2:1] == 2'b00;
        // a requester whose gnt is high is still holding the request it just had accepted
        cpu_el      = !vga_slot && bus.cpu_req && !cpu_gnt_q;
        dma_el      = !vga_slot && bus.dma_req && !dma_gnt_q;
        cpu_win     = cpu_el && (!dma_el || !last_cpu_q);
        dma_win     = dma_el && !cpu_win;
        mem_addr_d  = vga_slot ? bus.vga_addr : cpu_win ? bus.cpu_addr : dma_win ? bus.dma_addr : mem_addr_q;
        mem_wdata_d = cpu_win ? bus.cpu_wdata : dma_win ? bus.dma_wdata : mem_wdata_q;
        mem_we_d    = cpu_win ? bus.cpu_we : dma_win && bus.dma_we;
        tag_d       = vga_slot ? TAG_VGA : (cpu_win && !bus.cpu_we) ? TAG_CPU :
                      (dma_win && !bus.dma_we) ? TAG_DMA : TAG_NONE;
        last_cpu_d  = cpu_win ? 1'b1 : dma_win ? 1'b0 : last_cpu_q;
        ret         = tag_q[RD_LAT];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acnt_q       <= 3'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            last_cpu_q   <= 1'b0;
            vga_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            vga_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= TAG_NONE;
        end else begin
            acnt_q       <= acnt_q + 3'd1;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            cpu_gnt_q    <= cpu_win;
            dma_gnt_q    <= dma_win;
            last_cpu_q   <= last_cpu_d;
            tag_q[0]     <= tag_d;
            for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            vga_rvalid_q <= ret == TAG_VGA;
            cpu_rvalid_q <= ret == TAG_CPU;
            dma_rvalid_q <= ret == TAG_DMA;
            if (ret == TAG_VGA) vga_rdata_q <= bus.mem_rdata;
            if (ret == TAG_CPU) cpu_rdata_q <= bus.mem_rdata;
            if (ret == TAG_DMA) dma_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.acnt       = acnt_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dma_gnt    = dma_gnt_q;
    assign bus.vga_rdata  = vga_rdata_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rdata  = dma_rdata_q;
    assign bus.vga_rvalid = vga_rvalid_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dma_rvalid = dma_rvalid_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with per-owner read scoreboards and a write scoreboard.
module tb_mem_arbiter;
    localparam int DW = 16;

    typedef struct packed {logic [15:0] data; logic [2:0] at;} rd_t;
    typedef struct packed {logic [15:0] addr; logic [15:0] data;} wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATAWIDTH(DW)) bus();
    mem_arbiter #(.DATAWIDTH(DW), .RD_LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    rd_t vga_q[$];
    rd_t cpu_q[$];
    rd_t dma_q[$];
    wr_t wr_q[$];
    int total = 0;
    int bad = 0;
    logic [2:0] cnt;
    bit run = 0;
    bit vflag = 0;
    logic [15:0] va;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a == 16'h0123 ? 16'hBEEF : a + 16'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pop_rd(input int o, input logic [15:0] d);
        rd_t e;
        string n;
        int sz;
        n = o == 0 ? "vga" : o == 1 ? "cpu" : "dma";
        sz = o == 0 ? vga_q.size() : o == 1 ? cpu_q.size() : dma_q.size();
        if (sz == 0) begin
            total++;
            bad++;
            $display("FAIL %s_rvalid_unexpected: got rvalid with rdata %0h want no rvalid", n, d);
            return;
        end
        if (o == 0) e = vga_q.pop_front();
        else if (o == 1) e = cpu_q.pop_front();
        else e = dma_q.pop_front();
        chk({n, "_rdata"}, d, e.data);
        chk({n, "_rvalid_acnt"}, bus.acnt, e.at);
    endtask

    always @(posedge clk) cnt <= rst ? 3'd0 : cnt + 3'd1;
    always @(posedge clk) bus.mem_rdata <= memf(bus.mem_addr);

    always @(negedge clk) begin
        wr_t w;
        if (run && !rst) begin
            chk("acnt", bus.acnt, cnt);
            chk("one_rvalid", $countones({bus.vga_rvalid, bus.cpu_rvalid, bus.dma_rvalid}) <= 1, 1);
            chk("gnt_after_vga_slot", (bus.cpu_gnt || bus.dma_gnt) && (cnt == 3'd1 || cnt == 3'd2), 0);
            if (bus.vga_rvalid) pop_rd(0, bus.vga_rdata);
            if (bus.cpu_rvalid) pop_rd(1, bus.cpu_rdata);
            if (bus.dma_rvalid) pop_rd(2, bus.dma_rdata);
            if (bus.mem_we) begin
                if (wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL mem_we_unexpected: got mem_we=1 addr %0h want mem_we=0", bus.mem_addr);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", bus.mem_addr, w.addr);
                    chk("wr_data", bus.mem_wdata, w.data);
                end
            end
            if (vflag) begin
                chk("mem_addr_vga", bus.mem_addr, va);
                chk("mem_we_vga", bus.mem_we, 0);
            end
            vflag = cnt < 3'd2;
            va = bus.vga_addr;
            if (cnt < 3'd2) vga_q.push_back('{memf(bus.vga_addr), cnt + 3'd3});
        end else begin
            vga_q.delete();
            vflag = 0;
        end
    end

    task automatic wait_cnt(input logic [2:0] k);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (cnt == k) return;
        end
        total++;
        bad++;
        $display("FAIL wait_cnt: got no acnt=%0d want it within 16 cycles", k);
    endtask

    task automatic wait_gnt(input bit is_dma, output logic [2:0] at);
        at = 'x;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (is_dma ? bus.dma_gnt : bus.cpu_gnt) begin
                at = cnt;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL gnt_timeout: got no gnt (dma=%0d) want gnt within 10 cycles", is_dma);
    endtask

    initial begin
        logic [2:0] at;
        int cpu_n, dma_n, lastw;
        bit gc, gd;
        bus.vga_addr = 16'h0300;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acnt", bus.acnt, 0);
        chk("rst_gnt", {bus.cpu_gnt, bus.dma_gnt}, 0);
        chk("rst_rvalid", {bus.vga_rvalid, bus.cpu_rvalid, bus.dma_rvalid}, 0);
        chk("rst_mem", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_rdata", {bus.cpu_rdata, bus.vga_rdata}, 0);
        rst = 0;
        run = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("acnt_count", bus.acnt, i % 8);
        end

        // CPU read issued in slot 2
        wait_cnt(3'd2);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0123;
        wait_gnt(0, at);
        chk("cpu_rd_gnt_acnt", at, 3);
        chk("cpu_rd_mem_addr", bus.mem_addr, 16'h0123);
        chk("cpu_rd_mem_we", bus.mem_we, 0);
        cpu_q.push_back('{16'hBEEF, 3'd5});
        @(posedge clk); #1;
        bus.cpu_req = 0;
        repeat (6) @(posedge clk);

        // CPU read presented in a VGA slot waits for slot 2
        wait_cnt(3'd0);
        bus.cpu_req = 1; bus.cpu_addr = 16'h0222;
        wait_gnt(0, at);
        chk("cpu_slot0_gnt_acnt", at, 3);
        cpu_q.push_back('{16'h0223, 3'd5});
        @(posedge clk); #1;
        bus.cpu_req = 0;
        repeat (6) @(posedge clk);

        // CPU write
        wr_q.push_back('{16'h0040, 16'h5A5A});
        wait_cnt(3'd4);
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0040; bus.cpu_wdata = 16'h5A5A;
        wait_gnt(0, at);
        chk("cpu_wr_gnt_acnt", at, 5);
        chk("cpu_wr_mem_we", bus.mem_we, 1);
        @(posedge clk); #1;
        bus.cpu_req = 0; bus.cpu_we = 0;
        repeat (6) @(posedge clk);

        // DMA write in slot 7, granted in the following slot 0
        wr_q.push_back('{16'h7777, 16'h1234});
        wait_cnt(3'd7);
        bus.dma_req = 1; bus.dma_we = 1; bus.dma_addr = 16'h7777; bus.dma_wdata = 16'h1234;
        wait_gnt(1, at);
        chk("dma_wr_gnt_acnt", at, 0);
        @(posedge clk); #1;
        bus.dma_req = 0; bus.dma_we = 0;
        repeat (6) @(posedge clk);

        // VGA fetches
        wait_cnt(3'd0);
        bus.vga_addr = 16'h0500;
        @(posedge clk); #1;
        bus.vga_addr = 16'h0A13;
        @(posedge clk); #1;
        bus.vga_addr = 16'h0300;
        @(negedge clk);
        @(negedge clk);
        chk("vga0_rvalid", {bus.vga_rvalid, bus.acnt}, {1'b1, 3'd3});
        chk("vga0_rdata", bus.vga_rdata, 16'h0501);
        @(negedge clk);
        chk("vga1_rvalid", {bus.vga_rvalid, bus.acnt}, {1'b1, 3'd4});
        chk("vga1_rdata", bus.vga_rdata, 16'h0A14);
        @(negedge clk);
        chk("vga_hold", {bus.vga_rvalid, bus.vga_rdata}, {1'b0, 16'h0A14});

        // Contention: both hold requests; last grant was DMA so CPU leads
        wait_cnt(3'd2);
        bus.cpu_req = 1; bus.cpu_addr = 16'h1000;
        bus.dma_req = 1; bus.dma_addr = 16'h2000;
        cpu_n = 0; dma_n = 0; lastw = 1;
        repeat (32) begin
            @(negedge clk);
            gc = bus.cpu_gnt;
            gd = bus.dma_gnt;
            chk("both_gnt", gc && gd, 0);
            if (gc) begin
                chk("rr_alternate_cpu", lastw, 1);
                lastw = 0; cpu_n++;
                cpu_q.push_back('{memf(bus.cpu_addr), cnt + 3'd2});
            end
            if (gd) begin
                chk("rr_alternate_dma", lastw, 0);
                lastw = 1; dma_n++;
                dma_q.push_back('{memf(bus.dma_addr), cnt + 3'd2});
            end
            @(posedge clk); #1;
            if (gc) bus.cpu_addr = bus.cpu_addr + 16'd1;
            if (gd) bus.dma_addr = bus.dma_addr + 16'd1;
        end
        bus.cpu_req = 0;
        bus.dma_req = 0;
        chk("cont_cpu_grants", cpu_n, 12);
        chk("cont_dma_grants", dma_n, 12);
        repeat (8) @(posedge clk);

        // Reset the cycle after cpu_gnt: the read must be dropped
        wait_cnt(3'd2);
        bus.cpu_req = 1; bus.cpu_addr = 16'h0ABC;
        wait_gnt(0, at);
        chk("rst_rd_gnt_acnt", at, 3);
        @(posedge clk); #1;
        rst = 1;
        bus.cpu_req = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_acnt", bus.acnt, 0);
        chk("post_rst_gnt_rvalid", {bus.cpu_gnt, bus.dma_gnt, bus.cpu_rvalid, bus.dma_rvalid, bus.vga_rvalid}, 0);
        repeat (10) @(negedge clk);
        chk("post_rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("queues_drained", cpu_q.size() + dma_q.size() + wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Time-slot arbiter for the single shared SRAM/glyph-ROM port used by vga_ctrl, the CPU and the frame-buffer loader (DMA).
- Drives the 3-bit arbiter count `acnt`, a free-running 8-slot frame.
- Slots 0 and 1 are reserved for VGA fetches.
- Slots 2–7 go to CPU and DMA using round-robin with a request/grant handshake.
- Muxes address, write enable and write data onto the memory, and routes registered read data back to the owner with a fixed latency.

Parameters:
DATAWIDTH, 16, width of memory data and of all addresses
RD_LAT, 1, synchronous memory read latency in cycles (fixed at 1; any other value is unsupported)

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
acnt  out  3  slot counter 0..7; slot 0 = VGA glyph-number fetch, slot 1 = VGA pixel fetch
vga_addr  in  DATAWIDTH  VGA address, sampled at the edge ending slots 0 and 1
vga_rdata  out  DATAWIDTH  registered read data for VGA
vga_rvalid  out  1  one-cycle pulse when vga_rdata updates
cpu_req  in  1  CPU access request; level, held with addr/we/wdata until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  DATAWIDTH  CPU address
cpu_wdata  in  DATAWIDTH  CPU write data
cpu_gnt  out  1  one-cycle acceptance pulse
cpu_rvalid  out  1  one-cycle read-data-valid pulse
cpu_rdata  out  DATAWIDTH  registered read data
dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata  same widths and meanings as the cpu_* ports, for the loader
mem_addr  out  DATAWIDTH  registered memory address
mem_we  out  1  registered write strobe
mem_wdata  out  DATAWIDTH  registered write data
mem_rdata  in  DATAWIDTH  memory read data, valid one cycle after mem_addr

Behaviour:
- Reset (synchronous, active-high):
  - acnt=0; mem_addr=0, mem_we=0, mem_wdata=0.
  - All gnt, rvalid and rdata outputs = 0; vga_rdata=0.
  - Round-robin pointer favours CPU; the return-tag pipeline is flushed.
- acnt: +1 every cycle, wraps 7->0, never stalls.
- Slot ownership is decided in cycle T with acnt=k:
  - k∈{0,1}: VGA owns the slot unconditionally. At the edge ending T: mem_addr<=vga_addr, mem_we<=0, tag<=VGA.
  - k∈{2..7}: eligible requesters are those with req=1 and gnt=0 in cycle T. A requester whose gnt is currently high is excluded, so its held request is not granted twice.
    - One eligible requester: it wins.
    - Both eligible: the one that did not win the most recent contested or uncontested grant wins.
    - At the edge ending T: mem_addr, mem_we and mem_wdata <= winner's signals; winner gnt<=1 for cycle T+1; pointer updated; tag<=winner (reads only).
  - No winner: mem_we<=0, mem_addr and mem_wdata hold, tag<=NONE.
- Return path: mem_rdata is valid in T+2. At the edge ending T+2, the tagged owner's rdata<=mem_rdata and its rvalid=1 for exactly cycle T+3.
  - Read latency from req sampled (edge ending T) to rvalid high is 3 cycles.
  - VGA: the slot-0 fetch gives vga_rvalid in the acnt=3 cycle, slot 1 in acnt=4. Data is held until the next VGA capture.
- Writes: mem_we=1 for exactly one cycle (T+1). gnt is the only acknowledgement; no rvalid is issued for writes.
- Requester rules:
  - Keep req, addr, we and wdata stable until the cycle gnt is seen.
  - A new request may be presented from T+2 onward.
  - A single requester issuing back-to-back requests therefore gets at most one grant every 2 cycles.
- Fairness bound: a continuously asserted request is granted with gnt high no later than 4 cycles after the first sampling edge. Neither gnt is ever high during the cycle following slot 0 or 1 arbitration.
- Reset mid-operation: in-flight tags are discarded. No rvalid or gnt is asserted in the cycle after rst deasserts. acnt restarts at 0.
- rdata registers change only on their owner's capture edge.

Test Plan:
- Reset: hold rst 2 cycles -> acnt=0 and all gnt/rvalid/mem_we=0. Release rst -> acnt counts 0..7 and wraps to 0 after 8 cycles.
- CPU read: cpu_req=1, cpu_addr=0x0123, cpu_we=0 asserted at acnt=2 -> cpu_gnt in acnt=3 cycle, mem_addr=0x0123. Memory returns 0xBEEF -> cpu_rvalid pulse in acnt=5 with cpu_rdata=0xBEEF; vga/dma rvalid stay 0.
- CPU write: cpu_we=1, addr 0x0040, wdata 0x5A5A -> mem_we high exactly one cycle with mem_addr=0x0040 and mem_wdata=0x5A5A; no cpu_rvalid.
- Contention: cpu_req and dma_req held high over 32 cycles, each re-requesting 2 cycles after its gnt -> grants alternate CPU/DMA. No gnt results from slot 0/1 arbitration. mem_addr equals vga_addr on the edges ending acnt=0 and acnt=1.
- VGA: vga_addr=0x0500 at slot 0 and 0x0A13 at slot 1, memory models addr+1 -> vga_rvalid with 0x0501 at acnt=3, then 0x0A14 at acnt=4.
- Reset mid-read: rst asserted the cycle after cpu_gnt -> no cpu_rvalid ever appears, cpu_rdata=0, acnt=0 after release.
